// File: rtl/arbitro_rr16_pkg.sv
// Shared definitions for the 16-way round-robin arbiter: FSM encoding, sizes and the search result type.
// No logic here; latency and backpressure live in the modules that import it.
package arbitro_rr16_pkg;

    localparam int N_SOLICITANTES = 16;
    localparam int ANCHO_INDICE   = 4;

    typedef enum logic {
        LIBRE   = 1'b0,
        OCUPADO = 1'b1
    } estado_t;

    typedef struct packed {
        logic                    hallado;
        logic [ANCHO_INDICE-1:0] indice;
    } ganador_t;

endpackage

// File: rtl/arbitro_rr16_decodificador.sv
// 4-to-16 one-hot decoder with active-high enable; all outputs low when disabled.
// Purely combinational, zero latency; no flow control.
module Decodificador4a16 (
    input  logic [3:0]  Entrada,
    input  logic        Enable,
    output logic [15:0] Salida
);

    always_comb begin
        Salida = '0;
        if (Enable) begin
            Salida[Entrada] = 1'b1;
        end
    end

endmodule

// File: rtl/arbitro_rr16.sv
// Round-robin arbiter for 16 requesters with a bounded hold time of MAX_CICLOS cycles per grant.
// Grant appears 1 cycle after request/release is sampled; no backpressure, requesters simply hold Solicitud.
module arbitro_rr16
    import arbitro_rr16_pkg::*;
#(
    parameter int MAX_CICLOS = 15
) (
    input  logic                      Reloj,
    input  logic                      Reset,
    input  logic [N_SOLICITANTES-1:0] Solicitud,
    input  logic                      Liberar,
    output logic [N_SOLICITANTES-1:0] Concesion,
    output logic [ANCHO_INDICE-1:0]   Indice,
    output logic                      Valido,
    output logic                      Expirado
);

    localparam logic [ANCHO_INDICE-1:0] ULTIMO_CICLO = ANCHO_INDICE'(MAX_CICLOS - 1);

    estado_t                 estado, estado_sig;
    logic [ANCHO_INDICE-1:0] puntero, puntero_sig;
    logic [ANCHO_INDICE-1:0] indice, indice_sig;
    logic [ANCHO_INDICE-1:0] contador, contador_sig;
    logic                    expirado, expirado_sig;

    ganador_t ganador;
    logic     voluntario;
    logic     agotado;

    // First requester at or after the pointer, wrapping modulo 16.
    function automatic ganador_t buscar_ganador(
        input logic [N_SOLICITANTES-1:0] sol,
        input logic [ANCHO_INDICE-1:0]   ptr
    );
        ganador_t                g;
        logic [ANCHO_INDICE-1:0] cand;
        g.hallado = 1'b0;
        g.indice  = '0;
        for (int k = 0; k < N_SOLICITANTES; k++) begin
            cand = ptr + ANCHO_INDICE'(k);
            if (!g.hallado && sol[cand]) begin
                g.hallado = 1'b1;
                g.indice  = cand;
            end
        end
        return g;
    endfunction

    always_ff @(posedge Reloj) begin
        if (Reset) begin
            estado   <= LIBRE;
            puntero  <= '0;
            indice   <= '0;
            contador <= '0;
            expirado <= 1'b0;
        end else begin
            estado   <= estado_sig;
            puntero  <= puntero_sig;
            indice   <= indice_sig;
            contador <= contador_sig;
            expirado <= expirado_sig;
        end
    end

    always_comb begin
        estado_sig   = estado;
        puntero_sig  = puntero;
        indice_sig   = indice;
        contador_sig = contador;
        expirado_sig = 1'b0;

        ganador    = buscar_ganador(Solicitud, puntero);
        voluntario = Liberar || !Solicitud[indice];
        agotado    = (contador == ULTIMO_CICLO);

        case (estado)
            LIBRE: begin
                if (ganador.hallado) begin
                    estado_sig   = OCUPADO;
                    indice_sig   = ganador.indice;
                    puntero_sig  = ganador.indice + 1'b1;
                    contador_sig = '0;
                end
            end
            OCUPADO: begin
                if (voluntario || agotado) begin
                    // A voluntary release in the same cycle masks the timeout pulse.
                    expirado_sig = agotado && !voluntario;
                    if (ganador.hallado) begin
                        indice_sig   = ganador.indice;
                        puntero_sig  = ganador.indice + 1'b1;
                        contador_sig = '0;
                    end else begin
                        estado_sig = LIBRE;
                    end
                end else begin
                    contador_sig = contador + 1'b1;
                end
            end
            default: estado_sig = LIBRE;
        endcase
    end

    assign Indice   = indice;
    assign Valido   = (estado == OCUPADO);
    assign Expirado = expirado;

    Decodificador4a16 U1 (
        .Entrada (indice),
        .Enable  (Valido),
        .Salida  (Concesion)
    );

endmodule

// File: tb/tb_arbitro_rr16.sv
// Directed bench for arbitro_rr16 (MAX_CICLOS=4) with a cycle-accurate reference model and literal checkpoints.
module tb_arbitro_rr16;

    localparam int MAX = 4;

    logic        Reloj;
    logic        Reset;
    logic [15:0] Solicitud;
    logic        Liberar;
    logic [15:0] Concesion;
    logic [3:0]  Indice;
    logic        Valido;
    logic        Expirado;

    int pruebas = 0;
    int fallos  = 0;

    arbitro_rr16 #(.MAX_CICLOS(MAX)) dut (
        .Reloj     (Reloj),
        .Reset     (Reset),
        .Solicitud (Solicitud),
        .Liberar   (Liberar),
        .Concesion (Concesion),
        .Indice    (Indice),
        .Valido    (Valido),
        .Expirado  (Expirado)
    );

    initial Reloj = 1'b0;
    always #5 Reloj = ~Reloj;

    task automatic chk(input string nombre, input logic [31:0] actual, input logic [31:0] esperado);
        pruebas++;
        if (actual !== esperado) begin
            fallos++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nombre, actual, esperado, $time);
        end
    endtask

    // Reference model: m_uso counts how many cycles the current grant has been visible.
    logic m_listo = 1'b0;
    bit   m_val;
    int   m_idx, m_ptr, m_uso;
    bit   m_exp;
    bit   m_vol, m_agot;
    int   m_w;

    function automatic int ganador(input logic [15:0] s, input int p);
        for (int k = 0; k < 16; k++) begin
            if (s[(p + k) % 16]) return (p + k) % 16;
        end
        return -1;
    endfunction

    always @(posedge Reloj) begin
        if (Reset) begin
            m_val = 0; m_idx = 0; m_ptr = 0; m_uso = 0; m_exp = 0;
            m_listo = 1'b1;
        end else begin
            m_exp = 0;
            m_w   = ganador(Solicitud, m_ptr);
            if (m_val) begin
                m_vol  = Liberar || !Solicitud[m_idx];
                m_agot = (m_uso == MAX);
                if (m_vol || m_agot) begin
                    m_exp = m_agot && !m_vol;
                    if (m_w >= 0) begin
                        m_idx = m_w; m_ptr = (m_w + 1) % 16; m_uso = 1;
                    end else begin
                        m_val = 0;
                    end
                end else begin
                    m_uso++;
                end
            end else if (m_w >= 0) begin
                m_val = 1; m_idx = m_w; m_ptr = (m_w + 1) % 16; m_uso = 1;
            end
        end
    end

    always @(negedge Reloj) begin
        if (m_listo) begin
            chk("modelo.Valido",    32'(Valido),    32'(m_val));
            chk("modelo.Indice",    32'(Indice),    32'(m_idx));
            chk("modelo.Concesion", 32'(Concesion), m_val ? (32'd1 << m_idx) : 32'd0);
            chk("modelo.Expirado",  32'(Expirado),  32'(m_exp));
        end
    end

    task automatic paso(input logic [15:0] sol, input logic lib);
        Solicitud = sol;
        Liberar   = lib;
        @(negedge Reloj);
    endtask

    initial begin
        Reset = 1'b1; Solicitud = '0; Liberar = 1'b0;
        paso(16'h0000, 1'b0);
        paso(16'h0000, 1'b0);
        chk("reset.Concesion", 32'(Concesion), 32'h0);
        chk("reset.Indice",    32'(Indice),    32'h0);
        chk("reset.Valido",    32'(Valido),    32'h0);
        chk("reset.Expirado",  32'(Expirado),  32'h0);
        Reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            paso(16'h0000, 1'b0);
            chk("idle.Valido",    32'(Valido),    32'h0);
            chk("idle.Concesion", 32'(Concesion), 32'h0);
        end

        // 0x0081 with Liberar pulsed on every grant: 0 -> 7 -> 0
        paso(16'h0081, 1'b0);
        chk("rr.first.Indice",    32'(Indice),    32'h0);
        chk("rr.first.Concesion", 32'(Concesion), 32'h0001);
        paso(16'h0081, 1'b1);
        chk("rr.second.Indice",    32'(Indice),    32'h7);
        chk("rr.second.Concesion", 32'(Concesion), 32'h0080);
        paso(16'h0081, 1'b1);
        chk("rr.third.Indice",    32'(Indice),    32'h0);
        chk("rr.third.Concesion", 32'(Concesion), 32'h0001);
        paso(16'h0000, 1'b0);
        chk("rr.drop.Valido", 32'(Valido), 32'h0);
        chk("rr.drop.Indice", 32'(Indice), 32'h0);

        // Wrap-around with 0x8001: pointer is 1, so 15 wins, then the pointer wraps to 0
        paso(16'h8001, 1'b0);
        chk("wrap.first.Indice", 32'(Indice), 32'hF);
        chk("wrap.puntero",      32'(dut.puntero), 32'h0);
        paso(16'h8001, 1'b1);
        chk("wrap.second.Indice",    32'(Indice),    32'h0);
        chk("wrap.second.Concesion", 32'(Concesion), 32'h0001);
        paso(16'h0000, 1'b0);

        // Timeout: 0x0006 without Liberar, owner 1 holds exactly 4 cycles
        for (int i = 0; i < MAX; i++) begin
            paso(16'h0006, 1'b0);
            chk("timeout.hold.Indice",   32'(Indice),   32'h1);
            chk("timeout.hold.Expirado", 32'(Expirado), 32'h0);
        end
        paso(16'h0006, 1'b0);
        chk("timeout.next.Indice",   32'(Indice),   32'h2);
        chk("timeout.next.Expirado", 32'(Expirado), 32'h1);
        paso(16'h0006, 1'b0);
        chk("timeout.pulse_end", 32'(Expirado), 32'h0);
        paso(16'h0006, 1'b0);
        paso(16'h0006, 1'b0);
        paso(16'h0006, 1'b0);
        chk("timeout.back.Indice",   32'(Indice),   32'h1);
        chk("timeout.back.Expirado", 32'(Expirado), 32'h1);

        // Liberar on the timeout cycle: re-grant without Expirado
        paso(16'h0006, 1'b0);
        paso(16'h0006, 1'b0);
        paso(16'h0006, 1'b0);
        paso(16'h0006, 1'b1);
        chk("lib_timeout.Indice",   32'(Indice),   32'h2);
        chk("lib_timeout.Expirado", 32'(Expirado), 32'h0);

        // Reset while owner 2 has held for three cycles
        paso(16'h0006, 1'b0);
        paso(16'h0006, 1'b0);
        Reset = 1'b1;
        paso(16'h0006, 1'b0);
        chk("midreset.Concesion", 32'(Concesion), 32'h0);
        chk("midreset.Indice",    32'(Indice),    32'h0);
        chk("midreset.Valido",    32'(Valido),    32'h0);
        chk("midreset.Expirado",  32'(Expirado),  32'h0);
        Reset = 1'b0;
        paso(16'h0001, 1'b0);
        chk("postreset.Indice",    32'(Indice),    32'h0);
        chk("postreset.Concesion", 32'(Concesion), 32'h0001);

        // Sole requester times out and is re-granted to itself
        paso(16'h0001, 1'b0);
        paso(16'h0001, 1'b0);
        paso(16'h0001, 1'b0);
        paso(16'h0001, 1'b0);
        chk("solo.Indice",   32'(Indice),   32'h0);
        chk("solo.Valido",   32'(Valido),   32'h1);
        chk("solo.Expirado", 32'(Expirado), 32'h1);
        paso(16'h0000, 1'b0);
        paso(16'h0000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", pruebas, fallos);
        $finish;
    end

endmodule

// File: doc/arbitro_rr16.md
# arbitro_rr16

Round-robin arbiter that shares a 16-way resource among 16 requesters. It grants at most one requester at a time and enforces a bounded hold time. The grant is carried as a 4-bit index, and the one-hot grant vector is produced by the team's existing `Decodificador4a16` (4-to-16 decoder with active-high enable). The block sits in front of any 16-way shared bus or peripheral select in the design.

## Interface
Parameters:
- MAX_CICLOS, default 15: maximum consecutive cycles one owner may hold the grant. Legal range 1..15.

Ports (clock and reset are fixed: one clock, synchronous active-high reset):
- Reloj, input, 1: system clock. Everything is sampled on its rising edge.
- Reset, input, 1: synchronous, active-high reset.
- Solicitud, input, 16: request vector. Bit i high means requester i wants the resource.
- Liberar, input, 1: the current owner is done. Ignored when Valido=0.
- Concesion, output, 16: one-hot grant. Bit i is high iff Valido=1 and Indice=i.
- Indice, output, 4: index of the current owner.
- Valido, output, 1: a grant is active.
- Expirado, output, 1: one-cycle pulse marking a forced release by timeout.

## Operation
- FSM states: LIBRE (no owner) and OCUPADO (owner = Indice).
- Registered state:
  - Puntero (4 bit, priority start)
  - Indice
  - Valido
  - Contador (4 bit, hold counter)
  - Expirado
- Winner search: the first i with Solicitud[i]=1 in the order Puntero, Puntero+1, …, Puntero+15, taken mod 16 (15 wraps to 0).
- LIBRE:
  - If any Solicitud bit is set, the winner is granted next cycle: Indice←winner, Valido←1, Contador←0, Puntero←winner+1 mod 16, go to OCUPADO.
  - If no bit is set, stay in LIBRE.
- OCUPADO, release condition. Release happens when any of these is true:
  - Liberar=1;
  - Solicitud[Indice]=0;
  - Contador = MAX_CICLOS−1 (timeout).
- OCUPADO, no release: Contador←Contador+1.
- OCUPADO, on release:
  - Run a winner search over the current Solicitud. Puntero already points past the owner, so the owner has lowest priority.
  - A winner exists: re-grant directly (back-to-back, no idle cycle) and stay in OCUPADO.
  - No winner: Valido←0 and go to LIBRE. Indice keeps its last value.
- Owner still requesting and alone: the owner is re-granted as a new grant, and Contador restarts from 0.
- Expirado: registered, high for exactly the one cycle after a timeout release. It is 0 if Liberar=1 or Solicitud[Indice]=0 in the same cycle (voluntary release has priority).
- Concesion is purely combinational from Indice/Valido through the decoder. No extra register.

## Timing
- Reset values, one cycle after Reset=1 is sampled:
  - Concesion=0, Indice=0, Valido=0, Expirado=0
  - Puntero=0, Contador=0, state LIBRE
- Reset mid-grant drops the grant on the next edge. No Expirado pulse is generated.
- Request-to-grant latency from LIBRE: 1 cycle. Solicitud is sampled at edge n and Concesion is valid after edge n.
- Release-to-next-grant latency: 1 cycle. Ownership changes on the edge where release is sampled.
- Hold bound: an owner keeps Valido=1 for at most MAX_CICLOS consecutive cycles per grant.
- Inputs are synchronous to Reloj. No combinational path from Solicitud or Liberar to any output.

## Structure
- Shared package holds:
  - state encoding (LIBRE=0, OCUPADO=1)
  - N_SOLICITANTES=16
  - ANCHO_INDICE=4
- One sub-module: `Decodificador4a16`, instance U1, with Entrada=Indice, Enable=Valido, Salida=Concesion.
- The priority search is a function or combinational block inside `arbitro_rr16`. It is not a separate module.

## Test plan
- Reset, then Solicitud=16'h0000 for 5 cycles: Valido=0, Concesion=0 throughout.
- Solicitud=16'h0081 from reset, with Liberar pulsed each grant:
  - First grant is Indice=0 (Concesion=16'h0001).
  - Next is Indice=7 (16'h0080), then Indice=0 again.
  - Each handover takes 1 cycle.
- Wrap-around with Solicitud=16'h8001: grant 15 is followed by grant 0. Check that Puntero wraps 15→0.
- MAX_CICLOS=4, Solicitud=16'h0006, no Liberar:
  - Indice=1 holds exactly 4 cycles.
  - Indice=2 is then granted, with Expirado=1 for that one cycle.
- Liberar=1 in the same cycle as the timeout: re-grant happens and Expirado stays 0.
- Reset=1 while Valido=1 and Contador=2: on the next edge all outputs are 0. After reset deasserts, with Solicitud=16'h0001, the grant is again Indice=0.
